alu_multicycle: RTL and testbench

Parametrised, registered, multi-cycle integer ALU for the RISC-V execute stage, replacing the purely combinational ALU. Single-cycle ops (add/sub/logic/shift/compare) complete one cycle after acceptance. MUL runs as an iterative shift-add unit, and optional DIVU/REMU run as iterative restoring dividers. The pipeline talks to the block through valid/ready handshakes on both the operand and result sides.

---
 rtl/alu_multicycle.sv | 208 ++++++++++++++++++++
 tb/tb_alu_multicycle.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered multi-cycle integer ALU for the execute stage.
// Single-cycle ops finish one cycle after acceptance; MUL is an iterative
// shift-add unit taking WIDTH cycles. Defining the macro ALU_DIV_EN compiles in
// an iterative restoring divider for DIVU/REMU; without it those opcodes are
// reported as illegal. Operands and results use valid/ready handshakes.
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALUcontrol,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUresult,
  output logic             Zero,
  output logic             Illegal
);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t           state, state_nxt;
  logic [SHW-1:0]   cnt;       // iteration index, 0..WIDTH-1
  logic [WIDTH-1:0] op_a;      // multiplicand (shifts left) or divisor (fixed)
  logic [WIDTH-1:0] op_q;      // multiplier (shifts right) or dividend/quotient
  logic [WIDTH-1:0] acc;       // partial product or partial remainder
  logic             accept;
  logic             last;
  logic             wr_en;
  logic             wr_ill;
  logic [WIDTH-1:0] wr_val;
  logic             start_mul;
  logic             start_div;
  logic [WIDTH-1:0] mul_acc_nxt;

  // Single-cycle operations; returns {illegal, result}.
  function automatic logic [WIDTH:0] alu_single(input logic [3:0] op,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    logic signed [WIDTH-1:0] sa;
    logic signed [WIDTH-1:0] sb;
    logic [SHW-1:0]          sh;
    logic [WIDTH-1:0]        res;
    logic                    ill;
    sa  = a;
    sb  = b;
    sh  = b[SHW-1:0];
    res = '0;
    ill = 1'b0;
    case (op)
      4'b0010: res = a + b;
      4'b0110: res = a - b;
      4'b0000: res = a & b;
      4'b0001: res = a | b;
      4'b0111: res = a ^ b;
      4'b0100: res = a << sh;
      4'b0101: res = a >> sh;
      4'b1000: res = $unsigned(sa >>> sh);
      4'b1001: res = {{(WIDTH-1){1'b0}}, (sa < sb)};
      4'b1010: res = {{(WIDTH-1){1'b0}}, (a < b)};
      default: ill = 1'b1;
    endcase
    return {ill, res};
  endfunction

  assign InReady     = (state == IDLE) && (!OutValid || OutReady);
  assign accept      = InValid && InReady;
  assign last        = (cnt == SHW'(WIDTH - 1));
  assign mul_acc_nxt = acc + (op_q[0] ? op_a : '0);

`ifdef ALU_DIV_EN
  logic             is_rem;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  // A zero divisor always "fits", which yields all-ones quotient and remainder = A.
  always_comb begin
    rem_sh   = {acc, op_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, op_a};
    if (!rem_diff[WIDTH]) begin
      rem_nxt = rem_diff[WIDTH-1:0];
      quo_nxt = {op_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_nxt = rem_sh[WIDTH-1:0];
      quo_nxt = {op_q[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Next-state logic and result-write selection.
  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    wr_ill    = 1'b0;
    wr_val    = '0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (ALUcontrol)
            4'b0011: begin
              start_mul = 1'b1;
              state_nxt = MUL;
            end
`ifdef ALU_DIV_EN
            4'b1011, 4'b1100: begin
              start_div = 1'b1;
              state_nxt = DIV;
            end
`endif
            default: begin
              wr_en            = 1'b1;
              {wr_ill, wr_val} = alu_single(ALUcontrol, A, B);
            end
          endcase
        end
      end
      MUL: begin
        if (last) begin
          wr_en     = 1'b1;
          wr_val    = mul_acc_nxt;
          state_nxt = IDLE;
        end
      end
      DIV: begin
`ifdef ALU_DIV_EN
        if (last) begin
          wr_en     = 1'b1;
          wr_val    = is_rem ? rem_nxt : quo_nxt;
          state_nxt = IDLE;
        end
`else
        state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Iterative datapath: operand capture on accept, one bit per cycle while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      op_a <= '0;
      op_q <= '0;
      acc  <= '0;
`ifdef ALU_DIV_EN
      is_rem <= 1'b0;
`endif
    end else if (start_mul) begin
      cnt  <= '0;
      op_a <= A;
      op_q <= B;
      acc  <= '0;
    end else if (start_div) begin
      cnt  <= '0;
      op_a <= B;
      op_q <= A;
      acc  <= '0;
`ifdef ALU_DIV_EN
      is_rem <= (ALUcontrol == 4'b1100);
`endif
    end else if (state == MUL) begin
      cnt  <= cnt + SHW'(1);
      op_a <= op_a << 1;
      op_q <= op_q >> 1;
      acc  <= mul_acc_nxt;
    end else if (state == DIV) begin
`ifdef ALU_DIV_EN
      cnt  <= cnt + SHW'(1);
      op_q <= quo_nxt;
      acc  <= rem_nxt;
`endif
    end
  end

  // Result registers; flags derive from the value written on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUresult <= '0;
      Zero      <= 1'b0;
      Illegal   <= 1'b0;
      OutValid  <= 1'b0;
    end else if (wr_en) begin
      ALUresult <= wr_val;
      Zero      <= (wr_val == '0);
      Illegal   <= wr_ill;
      OutValid  <= 1'b1;
    end else if (OutReady) begin
      OutValid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (default WIDTH=32). Divider scenarios
// are included when ALU_DIV_EN is defined; otherwise opcode 1011 is checked
// as illegal.
module tb_alu_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        InValid = 1'b0;
  logic        InReady;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [3:0]  ALUcontrol = '0;
  logic        OutValid;
  logic        OutReady = 1'b1;
  logic [31:0] ALUresult;
  logic        Zero;
  logic        Illegal;

  int checks = 0;
  int errors = 0;

  alu_multicycle dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .A(A), .B(B), .ALUcontrol(ALUcontrol), .OutValid(OutValid),
    .OutReady(OutReady), .ALUresult(ALUresult), .Zero(Zero), .Illegal(Illegal)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      A = $urandom; B = $urandom; ALUcontrol = 4'($urandom); InValid = 1'b1;
      OutReady = 1'($urandom);
      @(posedge clk); #1;
      checks++;
      if (ALUresult !== 32'h0 || Zero !== 1'b0 || Illegal !== 1'b0 || OutValid !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold: result=%h zero=%b ill=%b ov=%b, required 0/0/0/0",
                 ALUresult, Zero, Illegal, OutValid);
      end
    end
    InValid = 1'b0; OutReady = 1'b1;
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1 || OutValid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: inready=%b ov=%b, required 1/0", InReady, OutValid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op[4]  = '{4'b0010, 4'b0110, 4'b1000, 4'b1001};
    logic [31:0] va[4]  = '{32'd5, 32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] vb[4]  = '{32'd7, 32'd7, 32'd4, 32'd1};
    logic [31:0] exp[4] = '{32'd12, 32'd0, 32'hF800_0000, 32'd1};
    OutReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (InReady !== 1'b1) begin
        errors++;
        $display("FAIL b2b_inready[%0d]: got %b, required 1", i, InReady);
      end
      A = va[i]; B = vb[i]; ALUcontrol = op[i]; InValid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b1 || ALUresult !== exp[i] || Zero !== (exp[i] == 0) || Illegal !== 1'b0) begin
        errors++;
        $display("FAIL b2b[%0d]: ov=%b result=%h zero=%b ill=%b, required 1 %h %b 0",
                 i, OutValid, ALUresult, Zero, Illegal, exp[i], (exp[i] == 0));
      end
    end
    InValid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (OutValid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain: ov=%b, required 0", OutValid);
    end
  endtask

  task automatic test_logic();
    logic [3:0]  op[7]  = '{4'b0000, 4'b0001, 4'b0111, 4'b0100, 4'b0101, 4'b1010, 4'b1010};
    logic [31:0] va[7]  = '{32'hF0F0_1234, 32'hF000_0000, 32'hFFFF_0000, 32'd1,
                            32'h8000_0000, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] vb[7]  = '{32'h0FF0_FFFF, 32'h0000_000F, 32'hFF00_FF00, 32'h0000_003F,
                            32'd4, 32'hFFFF_FFFF, 32'd1};
    logic [31:0] exp[7] = '{32'h00F0_1234, 32'hF000_000F, 32'h00FF_FF00, 32'h8000_0000,
                            32'h0800_0000, 32'd1, 32'd0};
    OutReady = 1'b1;
    for (int i = 0; i < 7; i++) begin
      A = va[i]; B = vb[i]; ALUcontrol = op[i]; InValid = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (OutValid !== 1'b1 || ALUresult !== exp[i] || Zero !== (exp[i] == 0)) begin
        errors++;
        $display("FAIL logic[%0d]: ov=%b result=%h zero=%b, required 1 %h %b",
                 i, OutValid, ALUresult, Zero, exp[i], (exp[i] == 0));
      end
    end
    InValid = 1'b0;
    @(posedge clk); #1;
  endtask

  // Runs one iterative op and checks OutValid rises exactly 32 cycles after accept.
  task automatic run_iter(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
    int bad = 0;
    OutReady = 1'b1;
    A = a; B = b; ALUcontrol = op; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0; A = 32'h1234_5678; B = 32'h9ABC_DEF0; ALUcontrol = 4'b0010;
    for (int c = 1; c <= 32; c++) begin
      OutReady = 1'(c & 1);
      if (c == 32) OutReady = 1'b1;
      @(posedge clk); #1;
      if (c < 32 && (OutValid !== 1'b0 || InReady !== 1'b0)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d cycles with ov/inready high, required 0", name, bad);
    end
    checks++;
    if (OutValid !== 1'b1 || ALUresult !== exp || Illegal !== 1'b0 || Zero !== (exp == 0)) begin
      errors++;
      $display("FAIL %s_result: ov=%b result=%h ill=%b, required 1 %h 0", name, OutValid,
               ALUresult, Illegal, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    run_iter("mul", 4'b0011, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run_iter("mul2", 4'b0011, 32'd1234, 32'd5678, 32'd7006652);
  endtask

  task automatic test_illegal();
`ifdef ALU_DIV_EN
    run_iter("divu", 4'b1011, 32'd100, 32'd7, 32'd14);
    run_iter("remu", 4'b1100, 32'd100, 32'd7, 32'd2);
    run_iter("divu0", 4'b1011, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run_iter("remu0", 4'b1100, 32'd5, 32'd0, 32'd5);
`else
    A = 32'd100; B = 32'd7; ALUcontrol = 4'b1011; InValid = 1'b1; OutReady = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (OutValid !== 1'b1 || Illegal !== 1'b1 || ALUresult !== 32'h0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL illegal_1011: ov=%b ill=%b result=%h zero=%b, required 1 1 0 1",
               OutValid, Illegal, ALUresult, Zero);
    end
`endif
    A = 32'd3; B = 32'd3; ALUcontrol = 4'b1111; InValid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (OutValid !== 1'b1 || Illegal !== 1'b1 || ALUresult !== 32'h0 || Zero !== 1'b1) begin
      errors++;
      $display("FAIL illegal_1111: ov=%b ill=%b result=%h zero=%b, required 1 1 0 1",
               OutValid, Illegal, ALUresult, Zero);
    end
    A = 32'd3; B = 32'd4; ALUcontrol = 4'b0010;
    @(posedge clk); #1;
    checks++;
    if (Illegal !== 1'b0 || ALUresult !== 32'd7) begin
      errors++;
      $display("FAIL illegal_clear: ill=%b result=%h, required 0 00000007", Illegal, ALUresult);
    end
    InValid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    OutReady = 1'b0;
    A = 32'd3; B = 32'd4; ALUcontrol = 4'b0010; InValid = 1'b1;
    @(posedge clk); #1;
    A = 32'd20; B = 32'd3; ALUcontrol = 4'b0110;
    for (int c = 0; c < 10; c++) begin
      if (OutValid !== 1'b1 || ALUresult !== 32'd7 || InReady !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: %0d bad stall cycles, required 0 (result=%h ov=%b inready=%b)",
               bad, ALUresult, OutValid, InReady);
    end
    OutReady = 1'b1;
    #1;
    checks++;
    if (InReady !== 1'b1) begin
      errors++;
      $display("FAIL bp_inready: got %b, required 1", InReady);
    end
    @(posedge clk); #1;
    checks++;
    if (OutValid !== 1'b1 || ALUresult !== 32'd17) begin
      errors++;
      $display("FAIL bp_accept: ov=%b result=%h, required 1 00000011", OutValid, ALUresult);
    end
    InValid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_mul();
    int seen = 0;
    OutReady = 1'b1;
    A = 32'd1; B = 32'd1; ALUcontrol = 4'b0010; InValid = 1'b1;
    @(posedge clk); #1;
    A = 32'hFFFF_FFFF; B = 32'd3; ALUcontrol = 4'b0011;
    @(posedge clk); #1;
    InValid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (ALUresult !== 32'h0 || OutValid !== 1'b0 || Zero !== 1'b0 || Illegal !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_clear: result=%h ov=%b zero=%b ill=%b, required 0 0 0 0",
               ALUresult, OutValid, Zero, Illegal);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (OutValid !== 1'b0 || InReady !== 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL rst_mid_idle: %0d cycles with ov=1 or inready=0, required 0", seen);
    end
    A = 32'd5; B = 32'd7; ALUcontrol = 4'b0010; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    checks++;
    if (OutValid !== 1'b1 || ALUresult !== 32'd12) begin
      errors++;
      $display("FAIL rst_mid_add: ov=%b result=%h, required 1 0000000c", OutValid, ALUresult);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_logic();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
